// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared internal data bus: one-hot registered grants,
// release on done / request withdrawal / hold-timer expiry, one turnaround cycle between owners.
//
// state | meaning
// IDLE  | no owner, arbitrating every cycle
// GRANT | grant[grant_id] drives the bus
// TURN  | one-cycle bus turnaround after a release, arbitrating for the next owner
module bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               bus_busy,
  output logic               timeout
);

  localparam int CNT_W     = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_LOAD = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_owner, last_owner_nxt;
  logic [ID_W-1:0]    grant_id_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [CNT_W-1:0]   hold_left, hold_left_nxt;
  logic               timeout_nxt;
  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic               rel_done, rel_drop, rel_timer;

  // Search starts just past the previous owner so it gets the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_found && req[(int'(last_owner) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = ID_W'((int'(last_owner) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    grant_id_nxt   = grant_id;
    last_owner_nxt = last_owner;
    hold_left_nxt  = hold_left;
    timeout_nxt    = 1'b0;
    rel_done       = done[grant_id];
    rel_drop       = !req[grant_id];
    rel_timer      = (MAX_HOLD != 0) && (hold_left == '0);
    case (state)
      IDLE, TURN: begin
        if (win_found) begin
          state_nxt      = GRANT;
          grant_nxt      = NUM_REQ'(1) << win_idx;
          grant_id_nxt   = win_idx;
          last_owner_nxt = win_idx;
          hold_left_nxt  = CNT_W'(HOLD_LOAD);
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_timer) begin
          state_nxt   = TURN;
          grant_nxt   = '0;
          // A concurrent normal release takes precedence over the timer.
          timeout_nxt = rel_timer && !rel_done && !rel_drop;
        end else if (hold_left != '0) begin
          hold_left_nxt = hold_left - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      grant_id   <= '0;
      bus_busy   <= 1'b0;
      timeout    <= 1'b0;
      hold_left  <= '0;
      last_owner <= ID_W'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      grant_id   <= grant_id_nxt;
      bus_busy   <= |grant_nxt;
      timeout    <= timeout_nxt;
      hold_left  <= hold_left_nxt;
      last_owner <= last_owner_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table plus hand-written multi-cycle sequences,
// expected outputs queued at drive time and compared one cycle later.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, done, grant;
  logic [1:0] grant_id;
  logic       bus_busy, timeout;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .bus_busy(bus_busy), .timeout(timeout)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] id;
    logic       to;
    string      name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] d,
                              input logic [3:0] eg, input logic [1:0] eid, input logic eto,
                              input string name);
    vec_t v;
    v.rst = r; v.req = q; v.done = d; v.grant = eg; v.id = eid; v.to = eto; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] d,
                      input logic [3:0] eg, input logic [1:0] eid, input logic eto,
                      input string name);
    exp_t e, act;
    @(negedge clk);
    reset = r; req = q; done = d;
    e.grant = eg; e.id = eid; e.busy = |eg; e.to = eto;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    act = {grant, grant_id, bus_busy, timeout};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b timeout=%b, want grant=%b id=%0d busy=%b timeout=%b",
               name, act.grant, act.id, act.busy, act.to, e.grant, e.id, e.busy, e.to);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req = '0; done = '0;

    // Reset, single requester, done release, regrant out of TURN, withdrawal
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, "t1_reset_a");
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, "t1_reset_b");
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, "t1_idle");
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t1_grant");
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t1_hold");
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t1_hold2");
    add(1, 4'b0001, 4'b0001, 4'b0000, 0, 0, "t1_done");
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t1_turn_regrant");
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, "t1_withdraw");
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, "t1_idle2");
    // Round robin with all requesting: 0,1,2,3,0, one empty cycle between owners
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, "t2_reset");
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      add(1, 4'b1111, 4'b0000, oh,      2'(k % 4), 0, "t2_grant");
      add(1, 4'b1111, 4'b0000, oh,      2'(k % 4), 0, "t2_hold");
      add(1, 4'b1111, oh,      4'b0000, 2'(k % 4), 0, "t2_release");
    end
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, "t2_idle");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].req, vecs[i].done, vecs[i].grant, vecs[i].id, vecs[i].to, vecs[i].name);

    // Hold timer: 8 grant cycles, timeout pulse, regrant
    for (int i = 0; i < 8; i++) step(1, 4'b0100, 4'b0000, 4'b0100, 2, 0, "t3_hold");
    step(1, 4'b0100, 4'b0000, 4'b0000, 2, 1, "t3_timeout");
    step(1, 4'b0100, 4'b0000, 4'b0100, 2, 0, "t3_regrant");
    step(1, 4'b0000, 4'b0000, 4'b0000, 2, 0, "t3_withdraw");
    step(1, 4'b0000, 4'b0000, 4'b0000, 2, 0, "t3_idle");

    // done coinciding with timer expiry is a normal release
    for (int i = 0; i < 8; i++) step(1, 4'b0100, 4'b0000, 4'b0100, 2, 0, "t6_hold");
    step(1, 4'b0100, 4'b0100, 4'b0000, 2, 0, "t6_done_and_timer");
    step(1, 4'b0000, 4'b0000, 4'b0000, 2, 0, "t6_idle");

    // Withdrawal without done; non-owner done ignored
    step(1, 4'b0010, 4'b0000, 4'b0010, 1, 0, "t4_grant");
    step(1, 4'b1010, 4'b1000, 4'b0010, 1, 0, "t4_nonowner_done");
    step(1, 4'b1010, 4'b0000, 4'b0010, 1, 0, "t4_hold");
    step(1, 4'b1000, 4'b0000, 4'b0000, 1, 0, "t4_withdraw");
    step(1, 4'b1000, 4'b0000, 4'b1000, 3, 0, "t4_turn_next");
    step(1, 4'b0000, 4'b0000, 4'b0000, 3, 0, "t4_release");
    step(1, 4'b0000, 4'b0000, 4'b0000, 3, 0, "t4_idle");

    // Reset during a grant, then req[0] wins first
    step(1, 4'b0010, 4'b0000, 4'b0010, 1, 0, "t5_grant");
    step(0, 4'b0010, 4'b0000, 4'b0000, 0, 0, "t5_reset_in_grant");
    step(1, 4'b0011, 4'b0000, 4'b0001, 0, 0, "t5_req0_first");
    step(1, 4'b0011, 4'b0001, 4'b0000, 0, 0, "t5_done");
    step(1, 4'b0011, 4'b0000, 4'b0010, 1, 0, "t5_then_req1");
    step(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, "t5_withdraw");
    step(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, "t5_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
